// File: rtl/mem_write_checker.sv
// Data-memory write monitor: compares processor stores against a table of expected
// (address, data) checkpoints and latches a pass/fail verdict with a cycle timeout.
module mem_write_checker #(
    parameter int ADDR_W  = 13,
    parameter int DATA_W  = 16,
    parameter int PC_W    = 16,
    parameter int N_CHECK = 4,
    parameter int ORDERED = 0,
    parameter int TIMEOUT = 100000
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        clear,
    input  logic                        mem_write,
    input  logic [ADDR_W-1:0]           data_adr,
    input  logic [DATA_W-1:0]           write_data,
    input  logic [PC_W-1:0]             pc,
    input  logic [N_CHECK-1:0]          exp_en,
    input  logic [N_CHECK*ADDR_W-1:0]   exp_addr,
    input  logic [N_CHECK*DATA_W-1:0]   exp_data,
    output logic                        done,
    output logic                        pass,
    output logic                        fail,
    output logic                        timeout,
    output logic [N_CHECK-1:0]          matched,
    output logic [$clog2(N_CHECK):0]    fail_idx,
    output logic [DATA_W-1:0]           fail_data,
    output logic [PC_W-1:0]             fail_pc,
    output logic [31:0]                 cycles
);

    localparam int IDX_W = $clog2(N_CHECK) + 1;
    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT - 1);

    typedef enum logic [1:0] {ST_RUN, ST_PASS, ST_FAIL} state_t;

    state_t              state_reg, state_next;
    logic [N_CHECK-1:0]  matched_reg, matched_next;
    logic [31:0]         cycles_reg, cycles_next;
    logic                timeout_reg, timeout_next;
    logic [IDX_W-1:0]    fail_idx_reg, fail_idx_next;
    logic [DATA_W-1:0]   fail_data_reg, fail_data_next;
    logic [PC_W-1:0]     fail_pc_reg, fail_pc_next;

    logic [N_CHECK-1:0]  addr_hit, data_hit, live, cand;
    logic [N_CHECK-1:0]  hit_onehot, matched_upd;
    logic [IDX_W-1:0]    hit_idx, cur_idx;
    logic                hit_any, hit_data_ok, in_order;
    logic                write_ev, match_ev, bad_ev, all_matched, tmo_ev;

    genvar gi;
    generate
        for (gi = 0; gi < N_CHECK; gi++) begin : g_slot
            assign addr_hit[gi] = (exp_addr[gi*ADDR_W +: ADDR_W] == data_adr);
            assign data_hit[gi] = (exp_data[gi*DATA_W +: DATA_W] == write_data);
        end
    endgenerate

    // live = slots still waiting; cand = live slots addressed by this write
    assign live = exp_en & ~matched_reg;
    assign cand = live & addr_hit;

    // Lowest-index candidate and lowest-index live slot (descending scan, last hit wins)
    always_comb begin
        hit_any     = 1'b0;
        hit_idx     = '0;
        hit_data_ok = 1'b0;
        hit_onehot  = '0;
        cur_idx     = '0;
        for (int i = N_CHECK - 1; i >= 0; i--) begin
            if (cand[i]) begin
                hit_any       = 1'b1;
                hit_idx       = IDX_W'(i);
                hit_data_ok   = data_hit[i];
                hit_onehot    = '0;
                hit_onehot[i] = 1'b1;
            end
            if (live[i]) begin
                cur_idx = IDX_W'(i);
            end
        end
    end

    // In ordered mode an addressed slot other than the current one is an order violation
    assign in_order    = (ORDERED == 0) || (hit_idx == cur_idx);
    assign write_ev    = (state_reg == ST_RUN) && mem_write && hit_any;
    assign match_ev    = write_ev && in_order && hit_data_ok;
    assign bad_ev      = write_ev && !(in_order && hit_data_ok);
    assign matched_upd = matched_reg | (match_ev ? hit_onehot : '0);
    assign all_matched = ((matched_upd & exp_en) == exp_en);
    assign tmo_ev      = (TIMEOUT != 0) && (cycles_reg == TIMEOUT_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= ST_RUN;
            matched_reg   <= '0;
            cycles_reg    <= '0;
            timeout_reg   <= 1'b0;
            fail_idx_reg  <= '0;
            fail_data_reg <= '0;
            fail_pc_reg   <= '0;
        end else begin
            state_reg     <= state_next;
            matched_reg   <= matched_next;
            cycles_reg    <= cycles_next;
            timeout_reg   <= timeout_next;
            fail_idx_reg  <= fail_idx_next;
            fail_data_reg <= fail_data_next;
            fail_pc_reg   <= fail_pc_next;
        end
    end

    // Verdict priority: bad write, then pass, then timeout
    always_comb begin
        state_next = state_reg;
        if (clear) begin
            state_next = ST_RUN;
        end else begin
            case (state_reg)
                ST_RUN: begin
                    if (bad_ev)           state_next = ST_FAIL;
                    else if (all_matched) state_next = ST_PASS;
                    else if (tmo_ev)      state_next = ST_FAIL;
                end
                default: state_next = state_reg;
            endcase
        end
    end

    always_comb begin
        matched_next   = matched_reg;
        cycles_next    = cycles_reg;
        timeout_next   = timeout_reg;
        fail_idx_next  = fail_idx_reg;
        fail_data_next = fail_data_reg;
        fail_pc_next   = fail_pc_reg;
        if (clear) begin
            matched_next   = '0;
            cycles_next    = '0;
            timeout_next   = 1'b0;
            fail_idx_next  = '0;
            fail_data_next = '0;
            fail_pc_next   = '0;
        end else if (state_reg == ST_RUN) begin
            matched_next = matched_upd;
            if (state_next == ST_RUN && cycles_reg != '1) begin
                cycles_next = cycles_reg + 32'd1;
            end
            if (bad_ev) begin
                fail_idx_next  = hit_idx;
                fail_data_next = write_data;
                fail_pc_next   = pc;
            end else if (!all_matched && tmo_ev) begin
                timeout_next   = 1'b1;
                fail_idx_next  = '1;
                fail_data_next = '0;
                fail_pc_next   = pc;
            end
        end
    end

    always_comb begin
        pass      = (state_reg == ST_PASS);
        fail      = (state_reg == ST_FAIL);
        done      = pass | fail;
        timeout   = timeout_reg;
        matched   = matched_reg;
        fail_idx  = fail_idx_reg;
        fail_data = fail_data_reg;
        fail_pc   = fail_pc_reg;
        cycles    = cycles_reg;
    end

endmodule
